// File: rtl/argmax_pkg.sv
// Shared definitions for the streaming argmax block: default widths,
// frame length and the three-state frame FSM encoding.
package argmax_pkg;

    localparam int BIT_DEF  = 16;  // score width, sign-magnitude
    localparam int N_DEF    = 10;  // scores per frame
    localparam int IDXW_DEF = 4;   // index width, 2^IDXW >= N

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_stream_top2_sm_greater.sv
// Combinational "a ranks strictly above b" for sign-magnitude scores.
// Ranking, strongest first: SAT (negative zero), positives by magnitude,
// +0, negatives with smaller magnitude winning. Equal rank gives 0 so the
// caller keeps the earlier arrival.
module sm_greater #(
    parameter int BIT = 16
) (
    input  logic [BIT-1:0] a,
    input  logic [BIT-1:0] b,
    output logic           a_gt_b
);

    localparam logic [BIT-1:0] SAT = {1'b1, {(BIT-1){1'b0}}};

    logic           a_sat;
    logic           b_sat;
    logic           a_neg;
    logic           b_neg;
    logic [BIT-2:0] a_mag;
    logic [BIT-2:0] b_mag;

    // Rank comparison: SAT first, then sign, then magnitude direction by sign.
    always_comb begin
        a_sat  = (a == SAT);
        b_sat  = (b == SAT);
        a_neg  = a[BIT-1];
        b_neg  = b[BIT-1];
        a_mag  = a[BIT-2:0];
        b_mag  = b[BIT-2:0];
        a_gt_b = 1'b0;
        if (b_sat) begin
            a_gt_b = 1'b0;
        end else if (a_sat) begin
            a_gt_b = 1'b1;
        end else if (!a_neg && b_neg) begin
            a_gt_b = 1'b1;
        end else if (a_neg && !b_neg) begin
            a_gt_b = 1'b0;
        end else if (!a_neg) begin
            a_gt_b = (a_mag > b_mag);
        end else begin
            a_gt_b = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/argmax_stream_top2.sv
// Streaming argmax: takes N sign-magnitude scores per frame, tracks best
// and second-best by rank, and presents the winner on a held result port.
//
// Handshake: a score transfers on a rising edge where s_valid && s_ready;
// a result transfers on a rising edge where m_valid && m_ready. Once
// m_valid is high it and all result fields stay stable until the transfer.
// s_valid offered while s_ready is low is dropped, never queued.
module argmax_stream_top2
    import argmax_pkg::*;
#(
    parameter int BIT     = BIT_DEF,
    parameter int N       = N_DEF,
    parameter int IDXW    = IDXW_DEF,
    parameter int REV_IDX = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BIT-1:0]  s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [BIT-1:0]  max_val,
    output logic [IDXW-1:0] max_idx,
    output logic [IDXW-1:0] sec_idx,
    output logic            sat_hit
);

    localparam int              CNTW = $clog2(N + 1);
    localparam logic [BIT-1:0]  SAT  = {1'b1, {(BIT-1){1'b0}}};
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [BIT-1:0]  best_val_q, best_val_d;
    logic [IDXW-1:0] best_pos_q, best_pos_d;
    logic [BIT-1:0]  sec_val_q, sec_val_d;
    logic [IDXW-1:0] sec_pos_q, sec_pos_d;
    logic            sec_vld_q, sec_vld_d;
    logic            sat_acc_q, sat_acc_d;
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;
    logic [BIT-1:0]  max_val_q, max_val_d;
    logic [IDXW-1:0] max_idx_q, max_idx_d;
    logic [IDXW-1:0] sec_idx_q, sec_idx_d;
    logic            sat_hit_q, sat_hit_d;

    logic            gt_best;
    logic            gt_sec;
    logic            accept;
    logic            load_out;
    logic [IDXW-1:0] new_pos;

    // Arrival position to reported index; comparisons always use arrival pos.
    function automatic logic [IDXW-1:0] map_idx(input logic [IDXW-1:0] p);
        if (REV_IDX != 0) begin
            return IDXW'(N - 1) - p;
        end
        return p;
    endfunction

    sm_greater #(.BIT(BIT)) u_gt_best (
        .a      (s_data),
        .b      (best_val_q),
        .a_gt_b (gt_best)
    );

    sm_greater #(.BIT(BIT)) u_gt_sec (
        .a      (s_data),
        .b      (sec_val_q),
        .a_gt_b (gt_sec)
    );

    // Next-state, running best/second update and result register load.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        best_val_d = best_val_q;
        best_pos_d = best_pos_q;
        sec_val_d  = sec_val_q;
        sec_pos_d  = sec_pos_q;
        sec_vld_d  = sec_vld_q;
        sat_acc_d  = sat_acc_q;
        m_valid_d  = m_valid_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        sec_idx_d  = sec_idx_q;
        sat_hit_d  = sat_hit_q;
        load_out   = 1'b0;
        accept     = s_valid && s_ready_q;
        new_pos    = IDXW'(count_q);

        if (clr) begin
            // Abort: drop the frame; result data stays but is invalid.
            state_d   = ST_IDLE;
            count_d   = '0;
            sec_vld_d = 1'b0;
            sat_acc_d = 1'b0;
            m_valid_d = 1'b0;
            sat_hit_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        best_val_d = s_data;
                        best_pos_d = '0;
                        sec_vld_d  = 1'b0;
                        sat_acc_d  = (s_data == SAT);
                        count_d    = CNTW'(1);
                        if (N == 1) begin
                            state_d  = ST_DONE;
                            load_out = 1'b1;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        if (gt_best) begin
                            sec_val_d  = best_val_q;
                            sec_pos_d  = best_pos_q;
                            sec_vld_d  = 1'b1;
                            best_val_d = s_data;
                            best_pos_d = new_pos;
                        end else if (gt_sec || !sec_vld_q) begin
                            sec_val_d = s_data;
                            sec_pos_d = new_pos;
                            sec_vld_d = 1'b1;
                        end
                        sat_acc_d = sat_acc_q | (s_data == SAT);
                        count_d   = count_q + 1'b1;
                        if (count_q == CNT_LAST) begin
                            state_d  = ST_DONE;
                            load_out = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (m_valid_q && m_ready) begin
                        state_d   = ST_IDLE;
                        m_valid_d = 1'b0;
                        count_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (load_out) begin
                max_val_d = best_val_d;
                max_idx_d = map_idx(best_pos_d);
                sec_idx_d = map_idx(sec_pos_d);
                sat_hit_d = sat_acc_d;
                m_valid_d = 1'b1;
            end
        end

        s_ready_d = (state_d != ST_DONE);
    end

    // State and data registers; reset clears everything including s_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            best_val_q <= '0;
            best_pos_q <= '0;
            sec_val_q  <= '0;
            sec_pos_q  <= '0;
            sec_vld_q  <= 1'b0;
            sat_acc_q  <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            max_val_q  <= '0;
            max_idx_q  <= '0;
            sec_idx_q  <= '0;
            sat_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            best_val_q <= best_val_d;
            best_pos_q <= best_pos_d;
            sec_val_q  <= sec_val_d;
            sec_pos_q  <= sec_pos_d;
            sec_vld_q  <= sec_vld_d;
            sat_acc_q  <= sat_acc_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            sec_idx_q  <= sec_idx_d;
            sat_hit_q  <= sat_hit_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign max_val = max_val_q;
    assign max_idx = max_idx_q;
    assign sec_idx = sec_idx_q;
    assign sat_hit = sat_hit_q;

endmodule

// File: tb/tb_argmax_stream_top2.sv
// Bench for argmax_stream_top2: two instances (forward and reversed index)
// share one stimulus stream; expected results are queued per instance and
// checked by monitors whenever m_valid is presented.
module tb_argmax_stream_top2;

    localparam int W  = 16;
    localparam int NS = 10;
    localparam int IW = 4;
    localparam logic [W-1:0] SAT = 16'h8000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b1;
    logic [W-1:0]  s_data = '0;

    logic          s_ready0, s_ready1;
    logic          m_valid0, m_valid1;
    logic [W-1:0]  max_val0, max_val1;
    logic [IW-1:0] max_idx0, max_idx1;
    logic [IW-1:0] sec_idx0, sec_idx1;
    logic          sat_hit0, sat_hit1;

    int errors = 0;
    int checks = 0;

    // expected entry: {max_val[24:9], best_pos[8:5], sec_pos[4:1], sat[0]}
    logic [24:0] exp_q0[$];
    logic [24:0] exp_q1[$];
    logic [W-1:0] frm [NS];

    argmax_stream_top2 #(.BIT(W), .N(NS), .IDXW(IW), .REV_IDX(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .m_valid(m_valid0), .m_ready(m_ready),
        .max_val(max_val0), .max_idx(max_idx0), .sec_idx(sec_idx0), .sat_hit(sat_hit0)
    );

    argmax_stream_top2 #(.BIT(W), .N(NS), .IDXW(IW), .REV_IDX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready),
        .max_val(max_val1), .max_idx(max_idx1), .sec_idx(sec_idx1), .sat_hit(sat_hit1)
    );

    // clock
    always #5 clk = ~clk;

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] pk(input logic [W-1:0] v, input logic [3:0] bp,
                                       input logic [3:0] sp, input logic s);
        return {v, bp, sp, s};
    endfunction

    function automatic logic [3:0] rev(input logic [3:0] p);
        logic [3:0] nm1;
        nm1 = 4'(NS - 1);
        return nm1 - p;
    endfunction

    task automatic push_exp(input logic [W-1:0] v, input logic [3:0] bp,
                            input logic [3:0] sp, input logic s);
        exp_q0.push_back(pk(v, bp, sp, s));
        exp_q1.push_back(pk(v, bp, sp, s));
    endtask

    // monitor, forward-index instance
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n && m_valid0) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected result: max_val=0x%0h max_idx=%0d", max_val0, max_idx0);
            end else begin
                e = exp_q0[0];
                chk("dut0 max_val", 32'(max_val0), 32'(e[24:9]));
                chk("dut0 max_idx", 32'(max_idx0), 32'(e[8:5]));
                chk("dut0 sec_idx", 32'(sec_idx0), 32'(e[4:1]));
                chk("dut0 sat_hit", 32'(sat_hit0), 32'(e[0]));
                if (m_ready) void'(exp_q0.pop_front());
            end
            chk("dut0 s_ready in DONE", 32'(s_ready0), 32'd0);
        end
    end

    // monitor, reversed-index instance
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n && m_valid1) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected result: max_val=0x%0h max_idx=%0d", max_val1, max_idx1);
            end else begin
                e = exp_q1[0];
                chk("dut1 max_val", 32'(max_val1), 32'(e[24:9]));
                chk("dut1 max_idx", 32'(max_idx1), 32'(rev(e[8:5])));
                chk("dut1 sec_idx", 32'(sec_idx1), 32'(rev(e[4:1])));
                chk("dut1 sat_hit", 32'(sat_hit1), 32'(e[0]));
                if (m_ready) void'(exp_q1.pop_front());
            end
            chk("dut1 s_ready in DONE", 32'(s_ready1), 32'd0);
        end
    end

    // drive one score and wait (bounded) for it to be accepted
    task automatic send(input logic [W-1:0] d, input int gap);
        int n;
        s_data  = d;
        s_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (s_ready0) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send: s_ready stayed 0 for score 0x%0h", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int cnt, input int gap);
        for (int i = 0; i < cnt; i++) send(frm[i], gap);
    endtask

    // wait (bounded) until both expected queues are consumed
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain: results outstanding q0=%0d q1=%0d", exp_q0.size(), exp_q1.size());
        end
        #1;
    endtask

    // stimulus
    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset s_ready", 32'(s_ready0), 32'd0);
        chk("reset m_valid", 32'(m_valid0), 32'd0);
        chk("reset max_val", 32'(max_val0), 32'd0);
        chk("reset max_idx", 32'(max_idx1), 32'd0);
        chk("reset sec_idx", 32'(sec_idx1), 32'd0);
        chk("reset sat_hit", 32'(sat_hit0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle s_ready", 32'(s_ready0), 32'd1);

        // positives with a tie on 9
        frm = '{16'd3, 16'd9, 16'd1, 16'd9, 16'd0, 16'd2, 16'd4, 16'd5, 16'd6, 16'd7};
        push_exp(16'd9, 4'd1, 4'd3, 1'b0);
        send_frame(NS, 0);
        chk("latency m_valid dut0", 32'(m_valid0), 32'd1);
        chk("latency m_valid dut1", 32'(m_valid1), 32'd1);
        drain();

        // all negatives: -2 best, -3 second
        frm = '{16'h8005, 16'h8002, 16'h8008, 16'h8009, 16'h8004,
                16'h8006, 16'h8003, 16'h800A, 16'h800B, 16'h8007};
        push_exp(16'h8002, 4'd1, 4'd6, 1'b0);
        send_frame(NS, 0);
        drain();

        // two SATs: the earlier stays best, the later becomes second
        frm = '{16'd1, 16'd2, SAT, 16'd3, 16'd4, 16'd5, SAT, 16'd6, 16'd7, 16'd8};
        push_exp(SAT, 4'd2, 4'd6, 1'b1);
        send_frame(NS, 0);
        drain();

        // sparse input, result held 6 cycles, a score offered during DONE
        m_ready = 1'b0;
        frm = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd25};
        push_exp(16'd90, 4'd8, 4'd7, 1'b0);
        send_frame(NS, 1);
        chk("hold m_valid start", 32'(m_valid0), 32'd1);
        s_data  = 16'h7000;
        s_valid = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("hold m_valid end", 32'(m_valid0), 32'd1);
        m_ready = 1'b1;
        drain();

        // equal values: earliest is best, next earliest is second
        frm = '{16'd7, 16'd7, 16'd7, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0};
        push_exp(16'd7, 4'd0, 4'd1, 1'b0);
        send_frame(NS, 0);
        drain();

        // clr after 6 accepts of a large partial frame, then +0 over negatives
        frm = '{16'h7FF0, 16'h7FF1, SAT, 16'h7FF3, 16'h7FF4, 16'h7FF5, 16'd0, 16'd0, 16'd0, 16'd0};
        send_frame(6, 0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr m_valid", 32'(m_valid0), 32'd0);
        chk("clr s_ready", 32'(s_ready0), 32'd1);
        chk("clr sat_hit", 32'(sat_hit0), 32'd0);
        frm = '{16'h8001, 16'h0000, 16'h8002, 16'h8003, 16'h8004,
                16'h8005, 16'h8006, 16'h8007, 16'h8008, 16'h8009};
        push_exp(16'h0000, 4'd1, 4'd0, 1'b0);
        send_frame(NS, 0);
        drain();

        // SAT at pos 4 beats 0x7FFF at pos 7
        frm = '{16'd5, 16'd100, 16'd0, 16'h8001, SAT, 16'd20, 16'd16, 16'h7FFF, 16'd3, 16'h8010};
        push_exp(SAT, 4'd4, 4'd7, 1'b1);
        send_frame(NS, 0);
        drain();

        // sub-cycle reset glitch mid-frame
        frm = '{16'd3, 16'd9, 16'd1, 16'd9, 16'd0, 16'd2, 16'd4, 16'd5, 16'd6, 16'd7};
        send_frame(4, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("glitch s_ready", 32'(s_ready0), 32'd0);
        chk("glitch m_valid", 32'(m_valid0), 32'd0);
        chk("glitch max_val", 32'(max_val0), 32'd0);
        chk("glitch max_idx dut1", 32'(max_idx1), 32'd0);
        chk("glitch sec_idx dut1", 32'(sec_idx1), 32'd0);
        chk("glitch sat_hit", 32'(sat_hit0), 32'd0);
        #1;
        rst_n = 1'b1;
        frm = '{16'h8005, 16'h8002, 16'h8008, 16'h8009, 16'h8004,
                16'h8006, 16'h8003, 16'h800A, 16'h800B, 16'h8007};
        push_exp(16'h8002, 4'd1, 4'd6, 1'b0);
        send_frame(NS, 0);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
